// File: rtl/unit_final_pkg.sv
// Shared types and constants for the ADC supervisor: frame layout, link FSM states
// and the default thresholds used as parameter defaults by the datapath.
package unit_final_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    GAP
  } adc_state_t;

  localparam int LEAD_ZEROS = 4;
  localparam int ADC_BITS   = 12;
  localparam int FRAME_BITS = LEAD_ZEROS + ADC_BITS;
  localparam int VOLT_W     = 16;

  localparam int DEF_CLK_DIV     = 25;
  localparam int DEF_GAP_PER     = 4;
  localparam int DEF_VREF_MV     = 3300;
  localparam int DEF_LED_STEP_MV = 600;
  localparam int DEF_V_LOW_MV    = 1000;
  localparam int DEF_V_HIGH_MV   = 3000;
  localparam int DEF_DEB_CYCLES  = 1000;

endpackage

// File: rtl/serial_adc_rx.sv
// 3-wire serial ADC reader: drives cs_n/adclk, samples ad_in on each adclk rise and
// presents the 12-bit code with a one-clk code_valid strobe at the end of every frame.
module serial_adc_rx
  import unit_final_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int GAP_PER = DEF_GAP_PER
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ad_in,
  output logic                adclk,
  output logic                cs_n,
  output logic [ADC_BITS-1:0] code,
  output logic                code_valid
);

  localparam int GAP_CLKS = GAP_PER * 2 * CLK_DIV;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam int EDGE_W   = $clog2(2 * FRAME_BITS);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CLKS - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * FRAME_BITS - 1);

  adc_state_t          state;
  logic [DIV_W-1:0]    div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [ADC_BITS-1:0] shift;

  logic half_done;
  logic sample_en;
  logic frame_done;

  assign half_done  = (state == CONV) && (div_cnt == DIV_LAST);
  assign sample_en  = half_done && !adclk;
  // The 32nd adclk toggle is the 16th fall: the frame ends there.
  assign frame_done = half_done && (edge_cnt == EDGE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cs_n       <= 1'b1;
      adclk      <= 1'b0;
      div_cnt    <= '0;
      edge_cnt   <= '0;
      gap_cnt    <= '0;
      code_valid <= 1'b0;
    end else begin
      code_valid <= frame_done;
      case (state)
        IDLE: begin
          state    <= CONV;
          cs_n     <= 1'b0;
          div_cnt  <= '0;
          edge_cnt <= '0;
        end
        CONV: begin
          if (half_done) begin
            div_cnt <= '0;
            adclk   <= !adclk;
            if (frame_done) begin
              state    <= GAP;
              cs_n     <= 1'b1;
              adclk    <= 1'b0;
              edge_cnt <= '0;
              gap_cnt  <= '0;
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= CONV;
            cs_n     <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Leading zeros fall off the top of the 12-bit shifter; a partial frame is overwritten.
  always_ff @(posedge clk) begin
    if (sample_en) shift <= {shift[ADC_BITS-2:0], ad_in};
    if (frame_done) code <= shift;
  end

endmodule

// File: rtl/unit_final_adc_monitor.sv
// Supply supervisor: scales serial ADC codes to millivolts, drives the LED bar graph
// and the supply-enable / alarm relays from the voltage and a debounced TEM input.
module unit_final_adc_monitor
  import unit_final_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int GAP_PER     = DEF_GAP_PER,
  parameter int VREF_MV     = DEF_VREF_MV,
  parameter int LED_STEP_MV = DEF_LED_STEP_MV,
  parameter int V_LOW_MV    = DEF_V_LOW_MV,
  parameter int V_HIGH_MV   = DEF_V_HIGH_MV,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic ad_in,
  input  logic TEM,
  output logic adclk,
  output logic cs_n,
  output logic K_1,
  output logic K_2,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5
);

  localparam int PROD_W = ADC_BITS + VOLT_W;
  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [VOLT_W-1:0] V_LOW    = VOLT_W'(V_LOW_MV);
  localparam logic [VOLT_W-1:0] V_HIGH   = VOLT_W'(V_HIGH_MV);
  localparam logic [VOLT_W-1:0] LED_TH1  = VOLT_W'(LED_STEP_MV);
  localparam logic [VOLT_W-1:0] LED_TH2  = VOLT_W'(2 * LED_STEP_MV);
  localparam logic [VOLT_W-1:0] LED_TH3  = VOLT_W'(3 * LED_STEP_MV);
  localparam logic [VOLT_W-1:0] LED_TH4  = VOLT_W'(4 * LED_STEP_MV);
  localparam logic [VOLT_W-1:0] LED_TH5  = VOLT_W'(5 * LED_STEP_MV);

  // Truncating scale: the low ADC_BITS of the product are dropped, never rounded.
  function automatic logic [VOLT_W-1:0] scale_mv(input logic [ADC_BITS-1:0] code);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(code) * PROD_W'(VREF_MV);
    return prod[ADC_BITS +: VOLT_W];
  endfunction

  function automatic logic [4:0] led_bar(input logic [VOLT_W-1:0] v);
    return {v >= LED_TH5, v >= LED_TH4, v >= LED_TH3, v >= LED_TH2, v >= LED_TH1};
  endfunction

  logic [ADC_BITS-1:0] code_p0;
  logic                vld_p0;
  logic [VOLT_W-1:0]   volt_p1;

  logic             tem_s1;
  logic             tem_s2;
  logic             tem_ok;
  logic [DEB_W-1:0] deb_cnt;

  serial_adc_rx #(
    .CLK_DIV (CLK_DIV),
    .GAP_PER (GAP_PER)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ad_in      (ad_in),
    .adclk      (adclk),
    .cs_n       (cs_n),
    .code       (code_p0),
    .code_valid (vld_p0)
  );

  // Any cycle where the synchronised input agrees with tem_ok restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tem_s1  <= 1'b0;
      tem_s2  <= 1'b0;
      tem_ok  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      tem_s1 <= TEM;
      tem_s2 <= tem_s1;
      if (tem_s2 == tem_ok) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        tem_ok  <= tem_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // p0 -> p1: scaled voltage, then p1 -> outputs: bar graph and relays
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      volt_p1                        <= '0;
      {LED5, LED4, LED3, LED2, LED1} <= '0;
      K_1                            <= 1'b0;
      K_2                            <= 1'b0;
    end else begin
      if (vld_p0) volt_p1 <= scale_mv(code_p0);
      {LED5, LED4, LED3, LED2, LED1} <= led_bar(volt_p1);
      K_1 <= (volt_p1 >= V_LOW) && (volt_p1 <= V_HIGH) && !tem_ok;
      K_2 <= tem_ok || (volt_p1 > V_HIGH);
    end
  end

endmodule

// File: tb/tb_unit_final_adc_monitor.sv
// Bench for unit_final_adc_monitor: a serial ADC model feeds codes, and outputs are
// compared with millivolt/threshold rules computed directly in plain arithmetic.
module tb_unit_final_adc_monitor;

  localparam int CLK_DIV     = 25;
  localparam int GAP_PER     = 4;
  localparam int VREF_MV     = 3300;
  localparam int LED_STEP_MV = 600;
  localparam int V_LOW_MV    = 1000;
  localparam int V_HIGH_MV   = 3000;
  localparam int DEB_CYCLES  = 1000;
  localparam int FRAME_CLKS  = (16 + GAP_PER) * 2 * CLK_DIV;
  localparam int CONV_CLKS   = 16 * 2 * CLK_DIV;

  localparam logic [11:0] BOUND_CODES [7] = '{12'h4D8, 12'h4D9, 12'h4DA, 12'hBA3,
                                              12'hE8B, 12'hE8C, 12'hE8D};

  logic clk = 1'b0;
  logic rst, ad_in, TEM;
  logic adclk, cs_n, K_1, K_2, LED1, LED2, LED3, LED4, LED5;
  logic [11:0] adc_code;
  bit   exp_tem;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  unit_final_adc_monitor #(
    .CLK_DIV     (CLK_DIV),
    .GAP_PER     (GAP_PER),
    .VREF_MV     (VREF_MV),
    .LED_STEP_MV (LED_STEP_MV),
    .V_LOW_MV    (V_LOW_MV),
    .V_HIGH_MV   (V_HIGH_MV),
    .DEB_CYCLES  (DEB_CYCLES)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ad_in (ad_in),
    .TEM   (TEM),
    .adclk (adclk),
    .cs_n  (cs_n),
    .K_1   (K_1),
    .K_2   (K_2),
    .LED1  (LED1),
    .LED2  (LED2),
    .LED3  (LED3),
    .LED4  (LED4),
    .LED5  (LED5)
  );

  // ADC: 4 zeros then the 12-bit code MSB first, next bit presented after each adclk fall.
  initial begin : adc_model
    logic [15:0] word;
    ad_in = 1'b0;
    forever begin
      @(negedge cs_n);
      word = {4'b0000, adc_code};
      for (int b = 0; b < 16; b++) begin
        ad_in = word[15];
        word  = word << 1;
        @(negedge adclk or posedge cs_n);
        if (cs_n) break;
      end
    end
  end

  function automatic int exp_volt(input int code);
    return (code * VREF_MV) / 4096;
  endfunction

  function automatic logic [4:0] exp_leds(input int v);
    int lit;
    lit = v / LED_STEP_MV;
    if (lit > 5) lit = 5;
    return 5'((1 << lit) - 1);
  endfunction

  function automatic logic exp_k1(input int v);
    return (v >= V_LOW_MV) && (v <= V_HIGH_MV) && !exp_tem;
  endfunction

  function automatic logic exp_k2(input int v);
    return exp_tem || (v > V_HIGH_MV);
  endfunction

  task automatic wait_cs(input logic level, input string name);
    int n;
    n = 0;
    while (cs_n !== level && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (cs_n !== level) begin
      checks++;
      errors++;
      $display("FAIL %s: cs_n stuck at %b, waiting for %b", name, cs_n, level);
    end
  endtask

  // Feeds one full frame of the given code and compares the settled outputs.
  task automatic test_code_frame(input logic [11:0] code, input string name);
    int ev;
    adc_code = code;
    wait_cs(1'b1, name);
    wait_cs(1'b0, name);
    wait_cs(1'b1, name);
    repeat (3) @(negedge clk);
    ev = exp_volt(int'(code));
    checks++;
    if (dut.volt_p1 !== 16'(ev)) begin
      errors++;
      $display("FAIL %s volt code=%h: got %0d expected %0d", name, code, dut.volt_p1, ev);
    end
    checks++;
    if ({LED5, LED4, LED3, LED2, LED1} !== exp_leds(ev)) begin
      errors++;
      $display("FAIL %s leds code=%h: got %b expected %b", name, code,
               {LED5, LED4, LED3, LED2, LED1}, exp_leds(ev));
    end
    checks++;
    if (K_1 !== exp_k1(ev) || K_2 !== exp_k2(ev)) begin
      errors++;
      $display("FAIL %s relays code=%h: got K_1=%b K_2=%b expected K_1=%b K_2=%b",
               name, code, K_1, K_2, exp_k1(ev), exp_k2(ev));
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    TEM = 1'b0;
    adc_code = 12'h800;
    exp_tem = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || adclk !== 1'b0) begin
      errors++;
      $display("FAIL reset_link: got cs_n=%b adclk=%b expected 1 0", cs_n, adclk);
    end
    checks++;
    if ({LED5, LED4, LED3, LED2, LED1, K_1, K_2} !== 7'b0 || dut.volt_p1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got leds=%b K=%b%b volt=%0d expected all 0",
               {LED5, LED4, LED3, LED2, LED1}, K_1, K_2, dut.volt_p1);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cs_n !== 1'b1) begin
      errors++;
      $display("FAIL release_hold: got cs_n=%b expected 1", cs_n);
    end
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b0) begin
      errors++;
      $display("FAIL first_fall: got cs_n=%b expected 0 one clk after release", cs_n);
    end
    n = 0;
    while (adclk !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != CLK_DIV) begin
      errors++;
      $display("FAIL first_rise: got %0d clk expected %0d", n, CLK_DIV);
    end
  endtask

  task automatic test_frame_timing();
    int n;
    wait_cs(1'b1, "timing");
    wait_cs(1'b0, "timing");
    n = 0;
    while (cs_n === 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != CONV_CLKS) begin
      errors++;
      $display("FAIL conv_len: got %0d clk expected %0d", n, CONV_CLKS);
    end
    while (cs_n === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != FRAME_CLKS) begin
      errors++;
      $display("FAIL frame_period: got %0d clk expected %0d", n, FRAME_CLKS);
    end
  endtask

  task automatic test_zero_tem();
    test_code_frame(12'h000, "zero");
    TEM = 1'b1;
    repeat (2 + DEB_CYCLES) @(posedge clk);
    @(negedge clk);
    checks++;
    if (K_2 !== 1'b0) begin
      errors++;
      $display("FAIL tem_early: got K_2=%b expected 0", K_2);
    end
    @(negedge clk);
    checks++;
    if (K_2 !== 1'b1 || K_1 !== 1'b0) begin
      errors++;
      $display("FAIL tem_latency: got K_1=%b K_2=%b expected 0 1", K_1, K_2);
    end
    TEM = 1'b0;
    repeat (DEB_CYCLES + 10) @(negedge clk);
    checks++;
    if (K_2 !== 1'b0) begin
      errors++;
      $display("FAIL tem_release: got K_2=%b expected 0", K_2);
    end
  endtask

  task automatic test_tem_pulse();
    int bad;
    test_code_frame(12'h800, "pulse_base");
    bad = 0;
    for (int i = 0; i < 999 + DEB_CYCLES + 10; i++) begin
      TEM = (i < 999);
      @(negedge clk);
      if (K_1 !== 1'b1 || K_2 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pulse_999: relays moved on %0d cycles, expected 0", bad);
    end
    for (int i = 0; i < DEB_CYCLES; i++) begin
      TEM = 1'b1;
      @(negedge clk);
    end
    TEM = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (K_2 !== 1'b0) begin
      errors++;
      $display("FAIL pulse_1000_early: got K_2=%b expected 0", K_2);
    end
    @(negedge clk);
    checks++;
    if (K_1 !== 1'b0 || K_2 !== 1'b1) begin
      errors++;
      $display("FAIL pulse_1000: got K_1=%b K_2=%b expected 0 1", K_1, K_2);
    end
    repeat (DEB_CYCLES + 10) @(negedge clk);
    checks++;
    if (K_1 !== 1'b1 || K_2 !== 1'b0) begin
      errors++;
      $display("FAIL pulse_release: got K_1=%b K_2=%b expected 1 0", K_1, K_2);
    end
  endtask

  task automatic test_boundaries();
    for (int i = 0; i < 7; i++) test_code_frame(BOUND_CODES[i], "boundary");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) test_code_frame(12'($urandom_range(4095, 0)), "random");
  endtask

  task automatic test_reset_mid();
    int   rises, n;
    logic prev;
    test_code_frame(12'hFFF, "pre_reset");
    adc_code = 12'hA5C;
    wait_cs(1'b1, "mid_reset");
    wait_cs(1'b0, "mid_reset");
    rises = 0;
    n = 0;
    prev = adclk;
    while (rises < 8 && n < 2000) begin
      @(negedge clk);
      n++;
      if (adclk === 1'b1 && prev === 1'b0) rises++;
      prev = adclk;
    end
    checks++;
    if (rises != 8) begin
      errors++;
      $display("FAIL mid_rises: got %0d adclk rises expected 8", rises);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cs_n !== 1'b1 || adclk !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_link: got cs_n=%b adclk=%b expected 1 0", cs_n, adclk);
    end
    checks++;
    if ({LED5, LED4, LED3, LED2, LED1, K_1, K_2} !== 7'b0 || dut.volt_p1 !== 16'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got leds=%b K=%b%b volt=%0d expected all 0",
               {LED5, LED4, LED3, LED2, LED1}, K_1, K_2, dut.volt_p1);
    end
    adc_code = 12'h9C4;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b0) begin
      errors++;
      $display("FAIL restart_fall: got cs_n=%b expected 0", cs_n);
    end
    wait_cs(1'b1, "restart");
    repeat (3) @(negedge clk);
    checks++;
    if (dut.volt_p1 !== 16'(exp_volt(12'h9C4)) ||
        {LED5, LED4, LED3, LED2, LED1} !== exp_leds(exp_volt(12'h9C4))) begin
      errors++;
      $display("FAIL restart_code: got volt=%0d leds=%b expected volt=%0d leds=%b",
               dut.volt_p1, {LED5, LED4, LED3, LED2, LED1},
               exp_volt(12'h9C4), exp_leds(exp_volt(12'h9C4)));
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_code_frame(12'h800, "mid");
    test_code_frame(12'hFFF, "full");
    test_zero_tem();
    test_tem_pulse();
    test_boundaries();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
